// File: rtl/br_table_seq.sv
// ============================================================================
// br_table_seq : resolves a WebAssembly br_table immediate (LEB128) from ROM
// Build option: BR_TABLE_LEB_CHECK_EN enables malformed-LEB128 detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module br_table_seq #(
  parameter int ROM_ADDR = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROM_ADDR-1:0] pc_in,
  input  logic [31:0]         index,
  output logic [ROM_ADDR-1:0] rom_addr,
  input  logic [7:0]          rom_data,
  output logic                busy,
  output logic                done,
  output logic [31:0]         depth,
  output logic [ROM_ADDR-1:0] next_pc,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    COUNT = 3'd2,
    SCAN  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [31:0]         idx, idx_nxt;
  logic [31:0]         cnt, cnt_nxt;
  logic [31:0]         entry, entry_nxt;
  logic [31:0]         acc, acc_nxt;
  logic [2:0]          shift_k, shift_k_nxt;
  logic                bad, bad_nxt;
  logic                done_nxt, err_nxt;
  logic [31:0]         depth_nxt;
  logic [ROM_ADDR-1:0] next_pc_nxt, rom_addr_nxt;

  logic [5:0]          sh;
  logic [31:0]         contrib, value;
  logic                last_byte, bad_byte, hit;

  assign busy = (state != IDLE);

  // Byte k of a value lands at bit 7*k; anything past byte 5 is beyond bit 31.
  assign sh        = 6'(shift_k) * 6'd7;
  assign contrib   = (shift_k < 3'd5) ? (32'(rom_data[6:0]) << sh) : 32'd0;
  assign value     = acc | contrib;
  assign last_byte = ~rom_data[7];
  assign hit       = (idx < cnt) ? (entry == idx) : (entry == cnt);

`ifdef BR_TABLE_LEB_CHECK_EN
  assign bad_byte = (shift_k == 3'd4) && (rom_data[7] || (|rom_data[6:4]));
`else
  assign bad_byte = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      entry    <= '0;
      acc      <= '0;
      shift_k  <= '0;
      bad      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      depth    <= '0;
      next_pc  <= '0;
      rom_addr <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      entry    <= entry_nxt;
      acc      <= acc_nxt;
      shift_k  <= shift_k_nxt;
      bad      <= bad_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      depth    <= depth_nxt;
      next_pc  <= next_pc_nxt;
      rom_addr <= rom_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    entry_nxt    = entry;
    acc_nxt      = acc;
    shift_k_nxt  = shift_k;
    bad_nxt      = bad;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    depth_nxt    = depth;
    next_pc_nxt  = next_pc;
    rom_addr_nxt = rom_addr;

    unique case (state)
      IDLE: begin
        if (start) begin
          idx_nxt      = index;
          rom_addr_nxt = pc_in;
          cnt_nxt      = '0;
          entry_nxt    = '0;
          acc_nxt      = '0;
          shift_k_nxt  = '0;
          bad_nxt      = 1'b0;
          state_nxt    = PRIME;
        end
      end

      PRIME: begin
        rom_addr_nxt = rom_addr + 1'b1;
        state_nxt    = COUNT;
      end

      COUNT, SCAN: begin
        rom_addr_nxt = rom_addr + 1'b1;
        if (bad_byte) begin
          bad_nxt   = 1'b1;
          state_nxt = FIN;
        end else if (!last_byte) begin
          acc_nxt     = value;
          shift_k_nxt = (shift_k < 3'd5) ? shift_k + 3'd1 : shift_k;
        end else begin
          acc_nxt     = '0;
          shift_k_nxt = '0;
          if (state == COUNT) begin
            cnt_nxt   = value;
            entry_nxt = '0;
            state_nxt = SCAN;
          end else begin
            if (hit) depth_nxt = value;
            if (entry == cnt) begin
              // rom_addr already runs one ahead of the byte just consumed.
              next_pc_nxt = rom_addr;
              state_nxt   = FIN;
            end else begin
              entry_nxt = entry + 32'd1;
            end
          end
        end
      end

      FIN: begin
        done_nxt  = 1'b1;
        err_nxt   = bad;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_br_table_seq.sv
// ============================================================================
// tb_br_table_seq : scoreboard bench for br_table_seq with a registered ROM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_br_table_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  pc_in;
  logic [31:0] index;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        busy, done, err;
  logic [31:0] depth;
  logic [5:0]  next_pc;

  logic [7:0]  mem [64];
  logic [7:0]  bq [$];

  typedef struct {
    logic [31:0] depth;
    logic [5:0]  npc;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb [$];

  int vectors    = 0;
  int miscompares = 0;

  br_table_seq #(.ROM_ADDR(6)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .index(index),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
    .depth(depth), .next_pc(next_pc), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] pc);
    for (int i = 0; i < bq.size(); i++) mem[6'(pc + i)] = bq[i];
  endtask

  // Drive one request, then pop the scoreboard entry when done appears.
  task automatic run(input logic [5:0] pc, input logic [31:0] idx_v,
                     input logic [31:0] exp_depth, input logic exp_err,
                     input int exp_lat, input bit inject);
    exp_t e, got;
    int   lat;
    load(pc);
    e.depth = exp_depth;
    e.npc   = 6'(pc + bq.size());
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    pc_in = pc; index = idx_v; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pc_in = 6'h00; index = 32'd0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 1) check("busy_mid", {31'b0, busy}, 32'd1);
      @(negedge clk);
      lat++;
      start = (inject && lat == 2);
    end
    start = 1'b0;
    check("done_seen", {31'b0, done}, 32'd1);
    got = sb.pop_front();
    if (done) begin
      check("latency", lat, got.lat);
      check("err", {31'b0, err}, {31'b0, got.err});
      if (!got.err) begin
        check("depth", depth, got.depth);
        check("next_pc", {26'b0, next_pc}, {26'b0, got.npc});
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("done_single", {31'b0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    reset = 1'b1; start = 1'b0; pc_in = '0; index = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_depth", depth, 32'd0);
    check("rst_npc", {26'b0, next_pc}, 32'd0);
    check("rst_addr", {26'b0, rom_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    bq = '{8'h02, 8'h00, 8'h01, 8'h02};
    run(6'h10, 32'd1, 32'd1, 1'b0, 6, 1'b0);
    run(6'h10, 32'd7, 32'd2, 1'b0, 6, 1'b0);
    run(6'h10, 32'd2, 32'd2, 1'b0, 6, 1'b0);
    run(6'h10, 32'hFFFF_FFFF, 32'd2, 1'b0, 6, 1'b0);
    run(6'h10, 32'd0, 32'd0, 1'b0, 6, 1'b1);

    bq = '{8'h00, 8'h03};
    run(6'h20, 32'd0, 32'd3, 1'b0, 4, 1'b0);

    bq = '{8'h01, 8'h80, 8'h01, 8'h05};
    run(6'h04, 32'd0, 32'd128, 1'b0, 6, 1'b0);
    run(6'h04, 32'd1, 32'd5, 1'b0, 6, 1'b0);

    // Table straddling the top of the address space.
    bq = '{8'h01, 8'h05, 8'h09};
    run(6'h3E, 32'd3, 32'd9, 1'b0, 5, 1'b0);

    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h07};
`ifdef BR_TABLE_LEB_CHECK_EN
    run(6'h28, 32'd0, 32'd0, 1'b1, 7, 1'b0);
`else
    run(6'h28, 32'd0, 32'd7, 1'b0, 9, 1'b0);
`endif

    // Reset mid-operation, then a fresh request.
    bq = '{8'h02, 8'h00, 8'h01, 8'h02};
    load(6'h10);
    @(negedge clk);
    pc_in = 6'h10; index = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_depth", depth, 32'd0);
    check("mid_rst_addr", {26'b0, rom_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", {31'b0, done}, 32'd0);
    end
    reset = 1'b0;
    run(6'h10, 32'd0, 32'd0, 1'b0, 6, 1'b0);
    run(6'h10, 32'd1, 32'd1, 1'b0, 6, 1'b0);

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/br_table_seq.md
BR_TABLE_SEQ -- requirements
Module: br_table_seq

Interface
REQ-001 SHALL have parameter ROM_ADDR, default 6, giving the ROM byte-address width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin resolving one br_table; sampled only in IDLE.
REQ-005 SHALL have port pc_in, input, ROM_ADDR bits: address of the first immediate byte (the LEB128 vector count).
REQ-006 SHALL have port index, input, 32 bits: unsigned i32 operand popped by the CPU; captured with start.
REQ-007 SHALL have port rom_addr, output, ROM_ADDR bits: registered ROM read address.
REQ-008 SHALL have port rom_data, input, 8 bits: ROM byte, valid one cycle after rom_addr.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when depth and next_pc are valid.
REQ-011 SHALL have port depth, output, 32 bits: resolved label depth; held until the next start.
REQ-012 SHALL have port next_pc, output, ROM_ADDR bits: address of the first byte after the table; held until the next start.
REQ-013 SHALL have port err, output, 1 bit: malformed-LEB128 flag; pulses together with done.

Function
REQ-014 SHALL implement the states IDLE, PRIME, COUNT, SCAN and FIN.
REQ-015 In IDLE with start=1, SHALL latch index, load rom_addr with pc_in and move to PRIME.
REQ-016 PRIME SHALL advance rom_addr by 1 and move to COUNT.
REQ-017 COUNT and SCAN SHALL consume one rom_data byte per cycle and advance rom_addr by 1 each cycle.
REQ-018 Each LEB128 byte SHALL contribute bits [6:0] at shift 7*k, where k is the byte number within the value; bit 7 = 1 means more bytes follow.
REQ-019 COUNT SHALL decode the unsigned vector count, then enter SCAN with entry counter 0.
REQ-020 SCAN SHALL decode count+1 entries; the last entry is the default.
REQ-021 SHALL capture entry i as depth when i == index and index < count.
REQ-022 SHALL capture the default entry as depth when index >= count (unsigned compare).
REQ-023 When the last byte of the default entry is consumed, SHALL set next_pc to the address one past that byte and move to FIN.
REQ-024 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-025 Latency: with N total immediate bytes, done SHALL be high in the cycle N+2 rising edges after the edge that sampled start.
REQ-026 SHALL ignore start while busy=1.
REQ-027 rom_addr SHALL wrap modulo 2^ROM_ADDR; next_pc wraps identically.
REQ-028 Count of 0 SHALL be legal; the default entry is then always selected.

Reset
REQ-029 Reset SHALL force state IDLE and set busy=0, done=0, err=0, depth=0, next_pc=0, rom_addr=0 and all internal counters/accumulators to 0, immediately and regardless of clk.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no done pulse; the first start sampled after reset deasserts SHALL be accepted.

Configuration
REQ-031 Macro BR_TABLE_LEB_CHECK_EN SHALL control LEB128 validation.
REQ-032 With BR_TABLE_LEB_CHECK_EN defined, a LEB128 value that is longer than 5 bytes, or whose 5th byte has any of bits [6:4] set, SHALL stop decoding, go to FIN, and pulse err=1 with done; depth and next_pc are then undefined.
REQ-033 With BR_TABLE_LEB_CHECK_EN undefined, bits beyond bit 31 SHALL be discarded, decoding continues until a byte with bit 7 = 0, and err SHALL be tied to 0.

Verification
REQ-034 Bytes 02 00 01 02 at pc 0x10, index=1 -> depth=1, next_pc=0x14, done 6 cycles after start, err=0.
REQ-035 Same table, index=7 -> depth=2 (default), next_pc=0x14.
REQ-036 Bytes 00 03, index=0 -> depth=3, next_pc=pc+2, done 4 cycles after start.
REQ-037 Bytes 01 80 01 05, index=0 -> depth=128, next_pc=pc+4; with index=1 -> depth=5.
REQ-038 With BR_TABLE_LEB_CHECK_EN defined, count bytes 80 80 80 80 80 00 -> err=1 pulses with done; without the macro -> err=0 and decoding continues.
REQ-039 Reset asserted 3 cycles after start -> busy=0 and no done pulse; a start after reset resolves correctly. Start pulsed while busy -> ignored, with a single done pulse for the first request.
